// File: rtl/toplevel_bus.sv
// Byte-stream request/response bridge executing byte-wide Wishbone cycles on an internal 16x32 register bank.
// Build option: define TOPLEVELBUS_BUSERR_EN to return Wishbone err for addresses >= 0x40 instead of aliasing.
module toplevel_bus (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_axis_tdata,
    input  logic       i_axis_tkeep,
    input  logic       i_axis_tvalid,
    output logic       i_axis_tready,
    input  logic       i_axis_tlast,
    input  logic       i_axis_tuser,
    output logic [7:0] o_axis_tdata,
    output logic       o_axis_tkeep,
    output logic       o_axis_tvalid,
    input  logic       o_axis_tready,
    output logic       o_axis_tlast,
    output logic       o_axis_tuser
);
    localparam logic [7:0] TYPE_RD     = 8'hA1;
    localparam logic [7:0] TYPE_WR     = 8'hA2;
    localparam logic [7:0] TYPE_RD_RSP = 8'hA3;
    localparam logic [7:0] TYPE_WR_RSP = 8'hA4;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_WRITE, S_READ, S_DRAIN, S_RESP} state_t;
    state_t state_reg, state_next;

    logic        ready_en_reg, is_write_reg, drop_reg, err_seen_reg;
    logic [2:0]  hdr_cnt_reg;
    logic [39:0] hdr_reg;
    logic [31:0] addr_reg, cur_addr_reg;
    logic [15:0] count_reg, wr_cnt_reg, fetch_cnt_reg;
    logic [16:0] out_idx_reg;
    logic        hold_valid_reg;
    logic [7:0]  hold_data_reg;
    logic [1:0]  rd_lane_reg;

    logic        wb_ack_reg, wb_err_reg, wb_we_reg;
    logic [31:0] wb_dat_r_reg;
    logic [511:0] bank_flat;

    logic        accept, type_ok, wb_busy, rd_ack, rd_avail;
    logic        stb_wr, stb_rd, wb_stb, wb_we, in_range;
    logic [3:0]  wb_sel, wb_idx;
    logic [31:0] wb_dat_w;
    logic [15:0] hdr_count, resp_count;
    logic [16:0] total;
    logic        is_hdr_byte, out_valid, out_last, out_fire, data_fire;
    logic [7:0]  hdr_byte, wb_lane_byte, rd_byte;
    logic        unused_bits;

    assign accept       = i_axis_tvalid && i_axis_tready;
    assign type_ok      = (i_axis_tdata == TYPE_RD) || (i_axis_tdata == TYPE_WR);
    assign hdr_count    = {hdr_reg[7:0], i_axis_tdata};
    assign wb_busy      = wb_ack_reg || wb_err_reg;
    assign rd_ack       = wb_busy && !wb_we_reg;
    assign rd_avail     = hold_valid_reg || rd_ack;
    assign wb_lane_byte = wb_dat_r_reg[{rd_lane_reg, 3'b000} +: 8];
    assign rd_byte      = hold_valid_reg ? hold_data_reg : wb_lane_byte;
    assign resp_count   = is_write_reg ? wr_cnt_reg : count_reg;
    assign total        = 17'd7 + (is_write_reg ? 17'd0 : {1'b0, count_reg});
    assign is_hdr_byte  = out_idx_reg < 17'd7;
    assign out_last     = out_idx_reg == (total - 17'd1);
    assign out_fire     = out_valid && o_axis_tready;
    assign data_fire    = out_fire && !is_hdr_byte;

    // Write strobe rides on the accepted data beat; the slave acks on the next cycle.
    assign stb_wr   = (state_reg == S_WRITE) && accept && !i_axis_tuser;
    // Read fetches run ahead of the output (prefetch during the header) one byte at a time.
    assign stb_rd   = (state_reg == S_RESP) && !is_write_reg && (fetch_cnt_reg < count_reg)
                      && !rd_avail && !wb_busy;
    assign wb_stb   = stb_wr || stb_rd;
    assign wb_we    = stb_wr;
    assign wb_sel   = 4'b0001 << cur_addr_reg[1:0];
    assign wb_dat_w = {4{i_axis_tdata}};
    assign wb_idx   = cur_addr_reg[5:2];
`ifdef TOPLEVELBUS_BUSERR_EN
    assign in_range = (cur_addr_reg[31:6] == 26'd0);
`else
    assign in_range = 1'b1;
`endif
    assign unused_bits = ^{i_axis_tkeep, cur_addr_reg[31:6]};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) begin
                if (i_axis_tuser || !type_ok) state_next = i_axis_tlast ? S_IDLE : S_DRAIN;
                else                          state_next = i_axis_tlast ? S_IDLE : S_HEADER;
            end
            S_HEADER: if (accept) begin
                if (i_axis_tuser)                    state_next = i_axis_tlast ? S_IDLE : S_DRAIN;
                else if (hdr_cnt_reg != 3'd5)        state_next = i_axis_tlast ? S_IDLE : S_HEADER;
                else if (i_axis_tlast)               state_next = S_RESP;
                else if (!is_write_reg)              state_next = S_READ;
                else                                 state_next = (hdr_count == 16'd0) ? S_DRAIN : S_WRITE;
            end
            S_WRITE: if (accept) begin
                if (i_axis_tuser)                          state_next = i_axis_tlast ? S_IDLE : S_DRAIN;
                else if (i_axis_tlast)                     state_next = S_RESP;
                else if (wr_cnt_reg + 16'd1 == count_reg)  state_next = S_DRAIN;
            end
            S_READ:  state_next = S_DRAIN;
            S_DRAIN: if (accept && i_axis_tlast)
                state_next = (drop_reg || i_axis_tuser) ? S_IDLE : S_RESP;
            S_RESP:  if (out_fire && out_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        i_axis_tready = 1'b0;
        out_valid     = 1'b0;
        case (state_reg)
            S_IDLE, S_HEADER, S_DRAIN: i_axis_tready = ready_en_reg;
            S_WRITE:                   i_axis_tready = ready_en_reg && !wb_busy;
            S_RESP:                    out_valid = is_hdr_byte || rd_avail;
            default: ;
        endcase
    end

    always_comb begin
        case (out_idx_reg[2:0])
            3'd0:    hdr_byte = is_write_reg ? TYPE_WR_RSP : TYPE_RD_RSP;
            3'd1:    hdr_byte = addr_reg[31:24];
            3'd2:    hdr_byte = addr_reg[23:16];
            3'd3:    hdr_byte = addr_reg[15:8];
            3'd4:    hdr_byte = addr_reg[7:0];
            3'd5:    hdr_byte = resp_count[15:8];
            default: hdr_byte = resp_count[7:0];
        endcase
    end

    assign o_axis_tkeep  = 1'b1;
    assign o_axis_tvalid = out_valid;
    assign o_axis_tdata  = out_valid ? (is_hdr_byte ? hdr_byte : rd_byte) : 8'h00;
    assign o_axis_tlast  = out_valid && out_last;
`ifdef TOPLEVELBUS_BUSERR_EN
    assign o_axis_tuser  = out_valid && out_last && (err_seen_reg || (rd_ack && wb_err_reg));
`else
    assign o_axis_tuser  = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ready_en_reg   <= 1'b0;
            is_write_reg   <= 1'b0;
            drop_reg       <= 1'b0;
            err_seen_reg   <= 1'b0;
            hdr_cnt_reg    <= '0;
            hdr_reg        <= '0;
            addr_reg       <= '0;
            cur_addr_reg   <= '0;
            count_reg      <= '0;
            wr_cnt_reg     <= '0;
            fetch_cnt_reg  <= '0;
            out_idx_reg    <= '0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            rd_lane_reg    <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept && state_reg == S_IDLE) begin
                is_write_reg  <= (i_axis_tdata == TYPE_WR);
                drop_reg      <= i_axis_tuser || !type_ok;
                hdr_cnt_reg   <= '0;
                wr_cnt_reg    <= '0;
                fetch_cnt_reg <= '0;
                out_idx_reg   <= '0;
                err_seen_reg  <= 1'b0;
            end else if (accept && i_axis_tuser) begin
                drop_reg <= 1'b1;
            end
            if (accept && state_reg == S_HEADER) begin
                hdr_reg     <= {hdr_reg[31:0], i_axis_tdata};
                hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
                if (hdr_cnt_reg == 3'd5) begin
                    addr_reg     <= hdr_reg[39:8];
                    cur_addr_reg <= hdr_reg[39:8];
                    count_reg    <= hdr_count;
                end
            end
            if (wb_stb) cur_addr_reg <= cur_addr_reg + 32'd1;
            if (stb_wr) wr_cnt_reg <= wr_cnt_reg + 16'd1;
            if (stb_rd) begin
                fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
                rd_lane_reg   <= cur_addr_reg[1:0];
            end
            if (wb_err_reg) err_seen_reg <= 1'b1;
            // Park a fetched byte until the sink takes it so the output stays stable under backpressure.
            if (rd_ack) hold_data_reg <= wb_lane_byte;
            hold_valid_reg <= rd_avail && !data_fire;
            if (out_fire) out_idx_reg <= out_idx_reg + 17'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wb_ack_reg   <= 1'b0;
            wb_err_reg   <= 1'b0;
            wb_we_reg    <= 1'b0;
            wb_dat_r_reg <= '0;
        end else begin
            wb_ack_reg <= wb_stb && in_range;
            wb_err_reg <= wb_stb && !in_range;
            wb_we_reg  <= wb_we;
            if (wb_stb && !wb_we)
                wb_dat_r_reg <= in_range ? bank_flat[{wb_idx, 5'b00000} +: 32] : 32'd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    word_reg <= '0;
                end else if (wb_stb && wb_we && in_range && wb_idx == 4'(gi)) begin
                    for (int ln = 0; ln < 4; ln++)
                        if (wb_sel[ln]) word_reg[8*ln +: 8] <= wb_dat_w[8*ln +: 8];
                end
            end
            assign bank_flat[32*gi +: 32] = word_reg;
        end
    endgenerate
endmodule

// File: tb/tb_toplevel_bus.sv
// Directed bench for toplevel_bus: request packets in, response bytes checked against hand-built expectations.
module tb_toplevel_bus;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_axis_tdata;
    logic       i_axis_tkeep, i_axis_tvalid, i_axis_tready, i_axis_tlast, i_axis_tuser;
    logic [7:0] o_axis_tdata;
    logic       o_axis_tkeep, o_axis_tvalid, o_axis_tready, o_axis_tlast, o_axis_tuser;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pkt [0:31];
    int         pkt_len;
    logic [7:0] exp_b [0:31];
    int         exp_len;
    logic       exp_user;

    toplevel_bus dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_axis_tdata(i_axis_tdata), .i_axis_tkeep(i_axis_tkeep), .i_axis_tvalid(i_axis_tvalid),
        .i_axis_tready(i_axis_tready), .i_axis_tlast(i_axis_tlast), .i_axis_tuser(i_axis_tuser),
        .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep), .o_axis_tvalid(o_axis_tvalid),
        .o_axis_tready(o_axis_tready), .o_axis_tlast(o_axis_tlast), .o_axis_tuser(o_axis_tuser)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic req_hdr(input logic [7:0] t, input logic [31:0] a, input logic [15:0] c);
        pkt[0] = t; pkt[1] = a[31:24]; pkt[2] = a[23:16]; pkt[3] = a[15:8]; pkt[4] = a[7:0];
        pkt[5] = c[15:8]; pkt[6] = c[7:0]; pkt_len = 7;
    endtask

    task automatic pb(input logic [7:0] b);
        pkt[pkt_len] = b; pkt_len++;
    endtask

    task automatic rsp_hdr(input logic [7:0] t, input logic [31:0] a, input logic [15:0] c);
        exp_b[0] = t; exp_b[1] = a[31:24]; exp_b[2] = a[23:16]; exp_b[3] = a[15:8]; exp_b[4] = a[7:0];
        exp_b[5] = c[15:8]; exp_b[6] = c[7:0]; exp_len = 7; exp_user = 1'b0;
    endtask

    task automatic eb(input logic [7:0] b);
        exp_b[exp_len] = b; exp_len++;
    endtask

    // Called at a negedge; returns at the negedge right after the final beat was accepted.
    task automatic send_pkt(input int user_idx, input string tag);
        int wait_n;
        for (int i = 0; i < pkt_len; i++) begin
            i_axis_tvalid = 1'b1;
            i_axis_tdata  = pkt[i];
            i_axis_tlast  = (i == pkt_len - 1);
            i_axis_tuser  = (i == user_idx);
            wait_n = 0;
            while (!i_axis_tready && wait_n < 50) begin
                @(negedge clk);
                wait_n++;
            end
            if (wait_n >= 50) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_in_timeout: observed tready 0 expected 1 at byte %0d", tag, i);
                i = pkt_len;
            end else begin
                @(negedge clk);
            end
        end
        i_axis_tvalid = 1'b0;
        i_axis_tlast  = 1'b0;
        i_axis_tuser  = 1'b0;
    endtask

    task automatic check_resp(input bit bp, input string tag);
        int  got = 0;
        bit  done = 0;
        bit  stall = 0;
        logic [7:0] prev = 8'h00;
        chk({tag, "_valid_timing"}, o_axis_tvalid, 1);
        for (int c = 0; c < 400 && !done; c++) begin
            o_axis_tready = bp ? ~o_axis_tready : 1'b1;
            if (stall) chk({tag, "_stable"}, o_axis_tdata, prev);
            if (o_axis_tvalid && o_axis_tready) begin
                chk($sformatf("%s_b%0d", tag, got), o_axis_tdata, exp_b[got]);
                chk($sformatf("%s_last%0d", tag, got), o_axis_tlast, (got == exp_len - 1));
                if (o_axis_tlast) begin
                    chk({tag, "_user"}, o_axis_tuser, exp_user);
                    done = 1;
                end
                got++;
                stall = 0;
            end else begin
                stall = o_axis_tvalid;
            end
            prev = o_axis_tdata;
            @(negedge clk);
        end
        chk({tag, "_len"}, got, exp_len);
        o_axis_tready = 1'b1;
    endtask

    task automatic check_no_resp(input string tag);
        int seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_axis_tvalid) seen++;
            @(negedge clk);
        end
        chk({tag, "_no_resp"}, seen, 0);
        chk({tag, "_ready"}, i_axis_tready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        i_axis_tdata = 8'h00; i_axis_tkeep = 1'b1; i_axis_tvalid = 1'b0;
        i_axis_tlast = 1'b0;  i_axis_tuser = 1'b0; o_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tready", i_axis_tready, 0);
        chk("rst_tvalid", o_axis_tvalid, 0);
        chk("rst_tdata",  o_axis_tdata, 8'h00);
        chk("rst_tkeep",  o_axis_tkeep, 1);
        chk("rst_tlast",  o_axis_tlast, 0);
        chk("rst_tuser",  o_axis_tuser, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", i_axis_tready, 1);
        chk("post_rst_tvalid", o_axis_tvalid, 0);

        // Write 11 22 33 44 to 0x10, then read back plain and under backpressure.
        req_hdr(8'hA2, 32'h10, 16'd4); pb(8'h11); pb(8'h22); pb(8'h33); pb(8'h44);
        send_pkt(-1, "wr10");
        rsp_hdr(8'hA4, 32'h10, 16'd4);
        check_resp(0, "wr10_rsp");

        req_hdr(8'hA1, 32'h10, 16'd4);
        send_pkt(-1, "rd10");
        rsp_hdr(8'hA3, 32'h10, 16'd4); eb(8'h11); eb(8'h22); eb(8'h33); eb(8'h44);
        check_resp(0, "rd10_rsp");

        req_hdr(8'hA1, 32'h10, 16'd4);
        send_pkt(-1, "rd10bp");
        check_resp(1, "rd10bp_rsp");

        // Preload bytes 2-3 of word 0, then a short write must leave them alone.
        req_hdr(8'hA2, 32'h02, 16'd2); pb(8'h5A); pb(8'hA5);
        send_pkt(-1, "wr02");
        rsp_hdr(8'hA4, 32'h02, 16'd2);
        check_resp(0, "wr02_rsp");

        req_hdr(8'hA2, 32'h00, 16'd4); pb(8'hAA); pb(8'hBB);
        send_pkt(-1, "short");
        rsp_hdr(8'hA4, 32'h00, 16'd2);
        check_resp(0, "short_rsp");

        req_hdr(8'hA1, 32'h00, 16'd4);
        send_pkt(-1, "rd00");
        rsp_hdr(8'hA3, 32'h00, 16'd4); eb(8'hAA); eb(8'hBB); eb(8'h5A); eb(8'hA5);
        check_resp(1, "rd00_rsp");

        // Malformed: header cut short, then unknown type.
        pkt[0] = 8'hA1; pkt[1] = 8'h00; pkt[2] = 8'h00; pkt_len = 3;
        send_pkt(-1, "cut");
        check_no_resp("cut");

        pkt[0] = 8'h55; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03; pkt_len = 4;
        send_pkt(-1, "type55");
        check_no_resp("type55");

        req_hdr(8'hA1, 32'h12, 16'd2);
        send_pkt(-1, "rd12");
        rsp_hdr(8'hA3, 32'h12, 16'd2); eb(8'h33); eb(8'h44);
        check_resp(0, "rd12_rsp");

        // Frame error on the first data byte: no response, nothing written.
        req_hdr(8'hA2, 32'h20, 16'd2); pb(8'h55); pb(8'h66);
        send_pkt(7, "tuser");
        check_no_resp("tuser");

        req_hdr(8'hA1, 32'h20, 16'd2);
        send_pkt(-1, "rd20");
        rsp_hdr(8'hA3, 32'h20, 16'd2); eb(8'h00); eb(8'h00);
        check_resp(0, "rd20_rsp");

        // COUNT=0 read is the bare header.
        req_hdr(8'hA1, 32'h10, 16'd0);
        send_pkt(-1, "cnt0");
        rsp_hdr(8'hA3, 32'h10, 16'd0);
        check_resp(0, "cnt0_rsp");

        // Extra byte past COUNT is drained and not written.
        req_hdr(8'hA2, 32'h08, 16'd1); pb(8'h77); pb(8'h88);
        send_pkt(-1, "extra");
        rsp_hdr(8'hA4, 32'h08, 16'd1);
        check_resp(0, "extra_rsp");

        req_hdr(8'hA1, 32'h08, 16'd2);
        send_pkt(-1, "rd08");
        rsp_hdr(8'hA3, 32'h08, 16'd2); eb(8'h77); eb(8'h00);
        check_resp(0, "rd08_rsp");

        // Out-of-range read.
        req_hdr(8'hA1, 32'h40, 16'd1);
        send_pkt(-1, "rd40");
        rsp_hdr(8'hA3, 32'h40, 16'd1);
`ifdef TOPLEVELBUS_BUSERR_EN
        eb(8'h00); exp_user = 1'b1;
`else
        eb(8'hAA); exp_user = 1'b0;
`endif
        check_resp(0, "rd40_rsp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
